// File: rtl/retreo_io_ctrl.sv
// retreo_io_ctrl: I/O controller for the ReTReO core.
// Per-channel input holding registers feed core reads; core writes go into a
// tagged show-ahead output FIFO. Stall is raised when a read targets an empty
// or nonexistent channel, or a write finds no FIFO slot. Override_Stall forces
// the request through and records the failure in a sticky error flag.
module retreo_io_ctrl #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    input  logic [CHANNELS-1:0]       In_Valid,
    output logic [CHANNELS-1:0]       In_Ready,
    input  logic                      Core_Rd,
    input  logic [CHAN_W-1:0]         Core_Rd_Chan,
    output logic [WIDTH-1:0]          Core_Rd_Data,
    input  logic                      Core_Wr,
    input  logic [CHAN_W-1:0]         Core_Wr_Chan,
    input  logic [WIDTH-1:0]          Core_Wr_Data,
    input  logic                      Override_Stall,
    output logic                      Stall,
    output logic [WIDTH-1:0]          Out_Data,
    output logic [CHAN_W-1:0]         Out_Chan,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    input  logic                      Err_Clr,
    output logic                      Underflow_Err,
    output logic                      Overflow_Err
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    // Input channel state
    logic [WIDTH-1:0]    hold_r [CHANNELS];
    logic [WIDTH-1:0]    last_r [CHANNELS];
    logic [CHANNELS-1:0] full_r;

    // Output FIFO state
    logic [WIDTH-1:0]    fifo_data_r [DEPTH];
    logic [CHAN_W-1:0]   fifo_chan_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                underflow_r;
    logic                overflow_r;

    // Combinational control
    logic                sel_valid_s;
    logic                sel_full_s;
    logic                rd_miss_s;
    logic                rd_hit_s;
    logic                fifo_full_s;
    logic                pop_s;
    logic                can_push_s;
    logic                wr_fail_s;
    logic                stall_s;
    logic                push_s;
    logic                underflow_set_s;
    logic                overflow_set_s;
    logic [WIDTH-1:0]    rd_data_s;

    // Read selection, stall decision and the resulting per-cycle actions
    always_comb begin
        sel_valid_s = (int'(Core_Rd_Chan) < CHANNELS);
        sel_full_s  = 1'b0;
        rd_data_s   = '0;
        if (sel_valid_s) begin
            sel_full_s = full_r[Core_Rd_Chan];
            rd_data_s  = full_r[Core_Rd_Chan] ? hold_r[Core_Rd_Chan] : last_r[Core_Rd_Chan];
        end else begin
            sel_full_s = 1'b0;
            rd_data_s  = '0;
        end
        fifo_full_s     = (cnt_r == CNT_W'(DEPTH));
        pop_s           = (cnt_r != '0) & Out_Ready;
        can_push_s      = ~fifo_full_s | pop_s;
        rd_miss_s       = Core_Rd & ~sel_full_s;
        wr_fail_s       = Core_Wr & ~can_push_s;
        // Stall depends only on inputs and registered state, never on itself
        stall_s         = (rd_miss_s | wr_fail_s) & ~Override_Stall;
        rd_hit_s        = Core_Rd & sel_full_s & ~stall_s;
        push_s          = Core_Wr & can_push_s & ~stall_s;
        underflow_set_s = rd_miss_s & Override_Stall;
        overflow_set_s  = wr_fail_s & Override_Stall;
    end

    // Input capture and consumption per channel; capture needs ~full, a hit needs full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                hold_r[c] <= '0;
                last_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (In_Valid[c] && !full_r[c]) begin
                    hold_r[c] <= In_Data[c*WIDTH +: WIDTH];
                    full_r[c] <= 1'b1;
                end else if (rd_hit_s && (Core_Rd_Chan == CHAN_W'(c))) begin
                    full_r[c] <= 1'b0;
                    last_r[c] <= hold_r[c];
                end else begin
                    full_r[c] <= full_r[c];
                end
            end
        end
    end

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_r[i] <= '0;
                fifo_chan_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= Core_Wr_Data;
                fifo_chan_r[wr_ptr_r] <= Core_Wr_Chan;
                wr_ptr_r              <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Sticky error flags; a new failure wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (underflow_set_s) begin
                underflow_r <= 1'b1;
            end else if (Err_Clr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (Err_Clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign In_Ready      = ~full_r;
    assign Core_Rd_Data  = rd_data_s;
    assign Stall         = stall_s;
    assign Out_Valid     = (cnt_r != '0);
    assign Out_Data      = (cnt_r != '0) ? fifo_data_r[rd_ptr_r] : '0;
    assign Out_Chan      = (cnt_r != '0) ? fifo_chan_r[rd_ptr_r] : '0;
    assign Underflow_Err = underflow_r;
    assign Overflow_Err  = overflow_r;

endmodule

// File: doc/retreo_io_ctrl.md
# retreo_io_ctrl

Parametrised I/O controller for the ReTReO core. It replaces the single fixed 16-bit input/output register pair with CHANNELS independent input holding registers and a tagged output FIFO. It generates the core's Stall when the core reads an empty input channel or writes a full FIFO. Override_Stall lets the core proceed anyway: the read returns the channel's last value, or the write is dropped, and a sticky error flag is set.

## Interface

Parameters:
- WIDTH, 16, data width of every channel and FIFO entry
- CHANNELS, 4, number of input channels (≥1); CHAN_W = max(1, clog2(CHANNELS)) is derived
- DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- In_Data  in  CHANNELS*WIDTH  external input data, channel c at bits [c*WIDTH +: WIDTH]
- In_Valid  in  CHANNELS  external input strobe per channel
- In_Ready  out  CHANNELS  channel holding register empty
- Core_Rd  in  1  core read request
- Core_Rd_Chan  in  CHAN_W  channel to read
- Core_Rd_Data  out  WIDTH  read data, combinational
- Core_Wr  in  1  core write request
- Core_Wr_Chan  in  CHAN_W  tag stored with written data
- Core_Wr_Data  in  WIDTH  write data
- Override_Stall  in  1  suppress Stall and force the request through
- Stall  out  1  combinational stall to the core
- Out_Data  out  WIDTH  FIFO head data (show-ahead)
- Out_Chan  out  CHAN_W  FIFO head tag
- Out_Valid  out  1  FIFO non-empty
- Out_Ready  in  1  downstream accepts head
- Err_Clr  in  1  clear both error flags
- Underflow_Err  out  1  sticky: forced read of an empty or invalid channel
- Overflow_Err  out  1  sticky: forced write to a full FIFO

## Operation

Input side:
- Per channel c, state is hold[c], full[c] and last[c]. In_Ready[c] = ~full[c].
- When In_Valid[c] & In_Ready[c]: hold[c] ← data and full[c] ← 1.

Read path:
- Core_Rd_Data = full[sel] ? hold[sel] : last[sel]. An out-of-range sel returns 0.
- A read hit is Core_Rd & full[sel] with Stall=0. It clears full[sel] and sets last[sel] ← hold[sel].
- A read miss is Core_Rd & ~full[sel], or an out-of-range sel. It stalls; see Stall rules below.

Write path (output FIFO, DEPTH entries of {chan, data}):
- can_push = ~fifo_full | (Out_Valid & Out_Ready), so a pop frees a slot in the same cycle.
- A write with can_push and Stall=0 pushes {Core_Wr_Chan, Core_Wr_Data}.
- A pop occurs when Out_Valid & Out_Ready. Push and pop can happen in the same cycle; the count then stays unchanged.
- Out_Data and Out_Chan read 0 when the FIFO is empty.

Stall rules:
- Stall = (rd_miss | (Core_Wr & ~can_push)) & ~Override_Stall.
- Stall=1 blocks both core operations atomically in that cycle: no consume, no push, no flag update. External capture and FIFO pop continue.
- With Override_Stall=1:
  - A read miss returns last[sel] (0 for an invalid channel) and sets Underflow_Err. full and last do not change.
  - A write with ~can_push is dropped and sets Overflow_Err.
  - Non-failing operations in the same cycle complete normally.

Error flags:
- Sticky until Err_Clr or reset.
- Set has priority over Err_Clr in the same cycle.

## Timing

- Reset (async, rst_n low), required values:
  - full = 0, so In_Ready = all 1s.
  - hold, last and the FIFO pointers/count are 0.
  - Out_Valid = 0, Out_Data = 0, Out_Chan = 0.
  - Both error flags are 0.
  - Stall follows its combinational equation.
- Reset asserted mid-operation discards all buffered data immediately.
- Input latency: a value captured at edge N is readable by the core (Core_Rd hit, no Stall) in cycle N+1.
- A channel is refilled at the earliest on the edge after it is consumed. In_Ready rises in the cycle after the hit.
- Write latency: a push at edge N gives Out_Valid=1 with that data in cycle N+1.
- FIFO throughput is one push and one pop per cycle. The FIFO holds exactly DEPTH entries, and its pointers wrap modulo DEPTH.
- Stall, Core_Rd_Data and can_push are combinational. There is no path from Stall back into its own inputs.

## Test plan

- Reset, then In_Valid[2] with 0x00A5. Read ch2 the next cycle: Core_Rd_Data=0x00A5, Stall=0. In_Ready[2] is 0, then 1 after the read.
- Core_Rd ch1 while empty: Stall=1 each cycle. Drive In_Data ch1=0x0004 with In_Valid[1]: the stall releases the cycle after capture and the read returns 0x0004.
- Forced read: Core_Rd of empty ch0 after ch0 previously delivered 0x1234, with Override_Stall=1. Response: Stall=0, Core_Rd_Data=0x1234, Underflow_Err=1. Err_Clr then clears it.
- Fill the FIFO with 4 writes (tags 0..3, data 0x10..0x13) while Out_Ready=0. A 5th write gives Stall=1. Raise Out_Ready in the same cycle: the write is accepted, the head pops 0x10/tag0, and Out_Valid stays 1.
- Forced write: FIFO full, Out_Ready=0, Core_Wr of 0xBEEF with Override_Stall=1. Response: Stall=0, no push, Overflow_Err=1. The next 4 pops return 0x10..0x13 only.
- Hold 2 FIFO entries and full[3]=1, then assert rst_n=0 mid-cycle. Out_Valid=0 and In_Ready=4'b1111 immediately, with no clock edge needed.
